// File: rtl/rf_access_arb.sv
// Register-file port arbiter: the CPU datapath owns the register file except for a
// single GRANT cycle in which a pending debug access is steered onto the rf_* port.
module rf_access_arb #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_idle,
   input  logic [1:0]  cpu_laddr,
   input  logic [1:0]  cpu_raddr,
   input  logic        cpu_lwrite,
   input  logic        cpu_hwrite,
   input  logic [15:0] cpu_data,
   input  logic        cpu_wp_clr,
   input  logic        cpu_wp_add,
   input  logic [2:0]  cpu_wp_imm,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [2:0]  dbg_addr,
   input  logic [15:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [15:0] dbg_rdata,
   output logic [15:0] rf_in,
   output logic [1:0]  rf_laddr,
   output logic [1:0]  rf_raddr,
   output logic [2:0]  rf_base,
   output logic        rf_lwrite,
   output logic        rf_hwrite,
   input  logic [15:0] rf_lout,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_GRANT = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [1:0] state;
   logic [3:0] wcnt;
   logic [2:0] wp;

   // Debug handshake: dbg_req is a level held by the requester until dbg_ack, a
   // one-cycle pulse. Once GRANT is reached the access completes even if dbg_req drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         wcnt  <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (dbg_req && cpu_idle) begin
                  state <= S_GRANT;
               end else if (dbg_req) begin
                  state <= S_WAIT;
                  wcnt  <= 4'd1;
               end
            end
            S_WAIT: begin
               if (!dbg_req) begin
                  state <= S_IDLE;
                  wcnt  <= 4'd0;
               end else if (cpu_idle || wcnt == WAIT_LIMIT) begin
                  state <= S_GRANT;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            S_GRANT: state <= S_ACK;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_rdata <= 16'd0;
      end else if (state == S_GRANT) begin
         // Writes also capture rf_lout, which reflects the falling-edge write.
         dbg_rdata <= rf_lout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= 3'd0;
      end else if (!cpu_stall) begin
         if (cpu_wp_clr) begin
            wp <= 3'd0;
         end else if (cpu_wp_add) begin
            wp <= wp + cpu_wp_imm;
         end
      end
   end

   assign cpu_stall = (state == S_GRANT);
   assign dbg_ack   = (state == S_ACK);
   assign fsm_state = state;

   always_comb begin
      rf_base   = wp;
      rf_laddr  = cpu_laddr;
      rf_raddr  = cpu_raddr;
      rf_in     = cpu_data;
      rf_lwrite = cpu_lwrite;
      rf_hwrite = cpu_hwrite;
      if (state == S_GRANT) begin
         rf_base   = dbg_addr;
         rf_laddr  = 2'd0;
         rf_raddr  = 2'd0;
         rf_in     = dbg_wdata;
         rf_lwrite = dbg_we;
         rf_hwrite = dbg_we;
      end
   end

endmodule

// File: tb/tb_rf_access_arb.sv
// Randomized bench for rf_access_arb: driver issues debug accesses and window-pointer
// commands, a negedge monitor checks rf_* steering and ack timing/data from queues.
module tb_rf_access_arb;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_idle;
   logic [1:0]  cpu_laddr, cpu_raddr;
   logic        cpu_lwrite, cpu_hwrite;
   logic [15:0] cpu_data;
   logic        cpu_wp_clr, cpu_wp_add;
   logic [2:0]  cpu_wp_imm;
   logic        cpu_stall;
   logic        dbg_req, dbg_we;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_wdata;
   logic        dbg_ack;
   logic [15:0] dbg_rdata;
   logic [15:0] rf_in;
   logic [1:0]  rf_laddr, rf_raddr;
   logic [2:0]  rf_base;
   logic        rf_lwrite, rf_hwrite;
   logic [15:0] rf_lout;
   logic [1:0]  fsm_state;

   rf_access_arb #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .cpu_idle(cpu_idle),
      .cpu_laddr(cpu_laddr), .cpu_raddr(cpu_raddr),
      .cpu_lwrite(cpu_lwrite), .cpu_hwrite(cpu_hwrite), .cpu_data(cpu_data),
      .cpu_wp_clr(cpu_wp_clr), .cpu_wp_add(cpu_wp_add), .cpu_wp_imm(cpu_wp_imm),
      .cpu_stall(cpu_stall), .dbg_req(dbg_req), .dbg_we(dbg_we),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
      .dbg_rdata(dbg_rdata), .rf_in(rf_in), .rf_laddr(rf_laddr),
      .rf_raddr(rf_raddr), .rf_base(rf_base), .rf_lwrite(rf_lwrite),
      .rf_hwrite(rf_hwrite), .rf_lout(rf_lout), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- register file model ----------------
   logic [15:0] rf_mem [8];
   logic        rf_init = 1'b0;
   assign rf_lout = rf_mem[rf_base + {1'b0, rf_laddr}];

   always @(negedge clk) begin
      if (!rf_init) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= 16'(i * 16'h1111) ^ 16'h5a5a;
         rf_init <= 1'b1;
      end else begin
         if (rf_lwrite === 1'b1) rf_mem[rf_base + {1'b0, rf_laddr}][7:0]  <= rf_in[7:0];
         if (rf_hwrite === 1'b1) rf_mem[rf_base + {1'b0, rf_laddr}][15:8] <= rf_in[15:8];
      end
   end

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [51:0] grant_q[$];   // {cycle, addr, we, wdata}
   logic [47:0] exp_q[$];     // {ack cycle, rdata}
   logic [15:0] shadow [8];
   logic [2:0]  exp_wp = 3'd0;
   logic        grant_now = 1'b0;
   logic        mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [51:0] g;
   logic [47:0] a;
   always @(negedge clk) begin
      if (mon_en) begin
         if (cpu_stall === 1'b1) begin
            if (grant_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_stall cyc %0d: got 1 expected 0", cyc);
            end else begin
               g = grant_q.pop_front();
               check("grant_cycle", 64'(cyc), 64'(g[51:20]));
               check("grant_base", 64'(rf_base), 64'(g[19:17]));
               check("grant_we", 64'({rf_lwrite, rf_hwrite}), 64'({g[16], g[16]}));
               check("grant_in", 64'(rf_in), 64'(g[15:0]));
               check("grant_lr", 64'({rf_laddr, rf_raddr}), 64'(0));
            end
         end else begin
            check("stall", 64'(cpu_stall), 64'(0));
            check("base", 64'(rf_base), 64'(exp_wp));
            check("lr_pass", 64'({rf_laddr, rf_raddr}), 64'({cpu_laddr, cpu_raddr}));
            check("in_pass", 64'(rf_in), 64'(cpu_data));
            check("we_pass", 64'({rf_lwrite, rf_hwrite}), 64'({cpu_lwrite, cpu_hwrite}));
         end
         if (dbg_ack !== 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_ack cyc %0d: got %0b expected 0", cyc, dbg_ack);
            end else begin
               a = exp_q.pop_front();
               check("ack_cycle", 64'(cyc), 64'(a[47:16]));
               check("ack_rdata", 64'(dbg_rdata), 64'(a[15:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Advance one cycle, fold the previous cycle's wp command into the model,
   // then drive fresh CPU-side stimulus (no CPU register writes by default).
   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) exp_wp = 3'd0;
      else if (!grant_now) begin
         if (cpu_wp_clr) exp_wp = 3'd0;
         else if (cpu_wp_add) exp_wp = exp_wp + cpu_wp_imm;
      end
      grant_now  = 1'b0;
      reset      = 1'b0;
      cpu_laddr  = 2'($urandom_range(0, 3));
      cpu_raddr  = 2'($urandom_range(0, 3));
      cpu_data   = 16'($urandom);
      cpu_lwrite = 1'b0;
      cpu_hwrite = 1'b0;
      cpu_wp_clr = ($urandom_range(0, 7) == 0);
      cpu_wp_add = 1'($urandom_range(0, 1));
      cpu_wp_imm = 3'($urandom_range(0, 7));
      cpu_idle   = 1'($urandom_range(0, 1));
   endtask

   // One debug access; lvl 0..4 sets how often the CPU is idle (0 never, 4 always).
   task automatic do_txn(input logic we, input logic [2:0] addr, input logic [15:0] wdata,
                         input int lvl);
      logic idle [MAX_WAIT + 1];
      int   j0, t0;
      for (int j = 0; j <= MAX_WAIT; j++) idle[j] = ($urandom_range(0, 3) < lvl);
      j0 = MAX_WAIT;
      for (int j = MAX_WAIT - 1; j >= 0; j--) if (idle[j]) j0 = j;
      tick();
      t0 = cyc;
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      cpu_idle = idle[0];
      grant_q.push_back({32'(t0 + j0 + 1), addr, we, wdata});
      exp_q.push_back({32'(t0 + j0 + 2), (we ? wdata : shadow[addr])});
      if (we) shadow[addr] = wdata;
      for (int j = 1; j <= j0; j++) begin
         tick();
         cpu_idle = idle[j];
      end
      tick();
      grant_now  = 1'b1;
      cpu_lwrite = 1'($urandom_range(0, 1));
      cpu_hwrite = 1'($urandom_range(0, 1));
      dbg_req    = 1'($urandom_range(0, 1));
      tick();
      dbg_req = 1'($urandom_range(0, 1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1; cpu_idle = 1'b0; cpu_laddr = 2'd0; cpu_raddr = 2'd0;
      cpu_lwrite = 1'b0; cpu_hwrite = 1'b0; cpu_data = 16'd0;
      cpu_wp_clr = 1'b0; cpu_wp_add = 1'b0; cpu_wp_imm = 3'd0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 3'd0; dbg_wdata = 16'd0;
      for (int i = 0; i < 8; i++) shadow[i] = 16'(i * 16'h1111) ^ 16'h5a5a;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 64'(dbg_ack), 64'(0));
      check("rst_rdata", 64'(dbg_rdata), 64'(0));
      check("rst_stall", 64'(cpu_stall), 64'(0));
      check("rst_base", 64'(rf_base), 64'(0));
      check("rst_state", 64'(fsm_state), 64'(0));
      exp_wp = 3'd0;
      mon_en = 1'b1;

      // window pointer: +5, +5 wraps to 2, clear beats add
      tick(); cpu_wp_clr = 1'b0; cpu_wp_add = 1'b1; cpu_wp_imm = 3'd5;
      tick(); check("wp_first", 64'(rf_base), 64'(5));
      cpu_wp_clr = 1'b0; cpu_wp_add = 1'b1; cpu_wp_imm = 3'd5;
      tick(); check("wp_second", 64'(rf_base), 64'(2));
      cpu_wp_clr = 1'b1; cpu_wp_add = 1'b1; cpu_wp_imm = 3'd3;
      tick(); check("wp_clr_wins", 64'(rf_base), 64'(0));

      // idle CPU write then read back; fully busy CPU read
      do_txn(1'b1, 3'd6, 16'hBEEF, 4);
      dbg_req = 1'b0;
      do_txn(1'b0, 3'd6, 16'h0000, 4);
      do_txn(1'b0, 3'd3, 16'h0000, 0);
      dbg_req = 1'b0;

      // request dropped in WAIT with wcnt = 2
      tick(); dbg_req = 1'b1; dbg_we = 1'b0; cpu_idle = 1'b0;
      tick(); cpu_idle = 1'b0;
      tick(); cpu_idle = 1'b0; dbg_req = 1'b0;
      tick(); check("abandon_idle", 64'(fsm_state), 64'(0));
      repeat (3) tick();

      // reset during GRANT of a write; the write itself must persist
      tick(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd2; dbg_wdata = 16'h1234;
      cpu_idle = 1'b1;
      grant_q.push_back({32'(cyc + 1), 3'd2, 1'b1, 16'h1234});
      shadow[2] = 16'h1234;
      tick(); grant_now = 1'b1; reset = 1'b1; dbg_req = 1'b0;
      tick();
      check("rstg_ack", 64'(dbg_ack), 64'(0));
      check("rstg_rdata", 64'(dbg_rdata), 64'(0));
      check("rstg_stall", 64'(cpu_stall), 64'(0));
      check("rstg_state", 64'(fsm_state), 64'(0));
      check("rstg_base", 64'(rf_base), 64'(0));
      do_txn(1'b0, 3'd2, 16'h0000, 4);

      // randomized accesses
      for (int n = 0; n < 80; n++) begin
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                $urandom_range(0, 4));
         if (!dbg_req && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
      end
      for (int i = 0; i < 8; i++) do_txn(1'b0, 3'(i), 16'h0000, $urandom_range(0, 4));
      dbg_req = 1'b0;
      repeat (8) tick();

      check("grant_q_drained", 64'(grant_q.size()), 64'(0));
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rf_access_arb.md
RF_ACCESS_ARB -- requirements
Module: rf_access_arb

Interface
REQ-001 Parameter MAX_WAIT, default 4, legal range 1..15: max cycles a pending debug request waits on a busy CPU before forced grant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_idle  input  1  CPU datapath not using register file this cycle.
REQ-005 cpu_laddr, cpu_raddr  input  2 each  CPU window-relative L/R register select.
REQ-006 cpu_lwrite, cpu_hwrite  input  1 each  CPU low/high byte write enables.
REQ-007 cpu_data  input  16  CPU write data.
REQ-008 cpu_wp_clr, cpu_wp_add  input  1 each  window-pointer clear/add commands.
REQ-009 cpu_wp_imm  input  3  window-pointer add amount.
REQ-010 cpu_stall  output  1  CPU must hold its request this cycle.
REQ-011 dbg_req  input  1  debug access request, level, held until dbg_ack.
REQ-012 dbg_we  input  1  debug write (1) / read (0).
REQ-013 dbg_addr  input  3  absolute register index 0..7.
REQ-014 dbg_wdata  input  16  debug write data.
REQ-015 dbg_ack  output  1  one-cycle completion pulse.
REQ-016 dbg_rdata  output  16  debug read data, registered.
REQ-017 rf_in  output  16  register file write data.
REQ-018 rf_laddr, rf_raddr  output  2 each  register file L/R select.
REQ-019 rf_base  output  3  register file window base.
REQ-020 rf_lwrite, rf_hwrite  output  1 each  register file byte write enables.
REQ-021 rf_lout  input  16  register file combinational L read port.

Function
REQ-022 Window pointer wp (3 bits): cpu_wp_clr -> 0; else cpu_wp_add -> wp + cpu_wp_imm mod 8; clr wins over add.
REQ-023 wp updates suppressed in any cycle cpu_stall = 1.
REQ-024 FSM states IDLE, WAIT, GRANT, ACK; wait counter wcnt 4 bits.
REQ-025 IDLE: dbg_req & cpu_idle -> GRANT; dbg_req & !cpu_idle -> WAIT, wcnt = 1; else stay.
REQ-026 WAIT: !dbg_req -> IDLE (request abandoned, no ack); cpu_idle or wcnt == MAX_WAIT -> GRANT; else wcnt + 1.
REQ-027 GRANT -> ACK unconditionally; dbg_rdata <= rf_lout at end of GRANT cycle, reads and writes alike.
REQ-028 ACK: dbg_ack = 1 for exactly this cycle; -> IDLE.
REQ-029 dbg_req deasserted during GRANT or ACK: access still completes, ack still pulses.
REQ-030 dbg_req still high in IDLE after ACK: treated as a new request.
REQ-031 Outside GRANT, rf_* outputs are combinational pass-through: rf_base = wp, rf_laddr/rf_raddr/rf_in/rf_lwrite/rf_hwrite = cpu counterparts.
REQ-032 In GRANT: rf_base = dbg_addr, rf_laddr = rf_raddr = 0, rf_in = dbg_wdata, rf_lwrite = rf_hwrite = dbg_we.
REQ-033 cpu_stall = 1 in GRANT only, combinational from state; CPU writes in that cycle are not forwarded.
REQ-034 Worst-case debug latency, req to ack: MAX_WAIT + 2 cycles; with cpu_idle high, 2 cycles (GRANT, then ACK).
REQ-035 Register file writes on falling edge; write data and enables stable for the whole GRANT cycle.

Reset
REQ-036 reset high at rising edge: state IDLE, wp = 0, wcnt = 0, dbg_ack = 0, dbg_rdata = 0, cpu_stall = 0; overrides all other inputs.
REQ-037 Reset mid-access (WAIT/GRANT/ACK): access aborted, no ack; a GRANT write already completed on the falling edge is not undone.

Verification
REQ-038 cpu_wp_add = 1, imm = 5, twice from reset -> rf_base 5 then 2; cpu_wp_clr & cpu_wp_add together -> 0.
REQ-039 cpu_idle = 1, dbg write addr 6, data 16'hBEEF -> GRANT next cycle with rf_base = 6, rf_lwrite = rf_hwrite = 1; ack following cycle; later read addr 6 -> dbg_rdata = 16'hBEEF.
REQ-040 cpu_idle = 0 permanently, MAX_WAIT = 4, dbg read -> cpu_stall high exactly one cycle; ack 6 cycles after req.
REQ-041 dbg_req dropped in WAIT with wcnt = 2 -> IDLE, no ack, no stall.
REQ-042 cpu_wp_add asserted during stalled GRANT cycle -> wp unchanged.
REQ-043 reset asserted in GRANT -> next cycle IDLE, dbg_ack = 0, all registered outputs zero.
